// File: rtl/memory_request_unit.sv
// ---------------------------------------------------------------------------
// memory_request_unit
//
// Sequences one instruction at a time through the cache port: fetches with
// iREN, optionally performs one data access with dREN/dWEN, then commits the
// instruction with pc_en. Also owns the LL/SC reservation (link register),
// which snooped writes from other agents can invalidate.
//
// Ports:
//   CLK, nRST                  clock, async active-low reset
//   dREN_in, dWEN_in           decoded load / store request
//   datomic_in, halt_in        decoded atomic flag (LL/SC), decoded HALT
//   daddr_in, dstore_in        effective address, store data
//   ihit, dhit, dload          cache handshakes and returned load data
//   snoop_inv, snoop_addr      invalidating write from another agent
//   iREN, dREN, dWEN           request handshakes to the cache
//   daddr, dstore              registered data address / store data
//   pc_en, load_data           commit strobe and writeback value
//   halt_out, link_valid       sticky halt flag, reservation present
// ---------------------------------------------------------------------------
module memory_request_unit (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        dREN_in,
    input  logic        dWEN_in,
    input  logic        datomic_in,
    input  logic        halt_in,
    input  logic [31:0] daddr_in,
    input  logic [31:0] dstore_in,
    input  logic        ihit,
    input  logic        dhit,
    input  logic [31:0] dload,
    input  logic        snoop_inv,
    input  logic [31:0] snoop_addr,
    output logic        iREN,
    output logic        dREN,
    output logic        dWEN,
    output logic [31:0] daddr,
    output logic [31:0] dstore,
    output logic        pc_en,
    output logic [31:0] load_data,
    output logic        halt_out,
    output logic        link_valid
);

    typedef enum logic [1:0] {IDLE, FETCH, DATA, HALTED} state_t;

    state_t      state, next_state;
    logic        op_write, op_write_n;
    logic        op_atomic, op_atomic_n;
    logic [31:0] daddr_n, dstore_n;
    logic        link_valid_n;
    logic [29:0] link_addr, link_addr_n;
    logic        snoop_hit;
    logic        sc_ok;
    logic        snoop_addr_unused;

    // Reservations are tracked per word, so the byte offset of a snooped
    // address never matters.
    assign snoop_addr_unused = ^snoop_addr[1:0];

    assign snoop_hit = snoop_inv && (snoop_addr[31:2] == link_addr);

    // An SC that arrives in the same cycle as a matching snoop must fail,
    // so the check uses the post-snoop view of the reservation.
    assign sc_ok = link_valid && !snoop_hit && (daddr_in[31:2] == link_addr);

    // State, registered operation and reservation. Reset drops every request
    // immediately and clears the link.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state      <= IDLE;
            op_write   <= 1'b0;
            op_atomic  <= 1'b0;
            daddr      <= '0;
            dstore     <= '0;
            link_valid <= 1'b0;
            link_addr  <= '0;
        end else begin
            state      <= next_state;
            op_write   <= op_write_n;
            op_atomic  <= op_atomic_n;
            daddr      <= daddr_n;
            dstore     <= dstore_n;
            link_valid <= link_valid_n;
            link_addr  <= link_addr_n;
        end
    end

    // Next-state and output decode. Priority in FETCH is halt, then store
    // (plain or SC), then load. A snoop hit clears the link by default; an
    // LL completing in the same cycle overrides that below.
    always_comb begin
        next_state   = state;
        iREN         = 1'b0;
        dREN         = 1'b0;
        dWEN         = 1'b0;
        pc_en        = 1'b0;
        load_data    = '0;
        halt_out     = 1'b0;
        op_write_n   = op_write;
        op_atomic_n  = op_atomic;
        daddr_n      = daddr;
        dstore_n     = dstore;
        link_valid_n = link_valid && !snoop_hit;
        link_addr_n  = link_addr;

        case (state)
            IDLE: begin
                next_state = FETCH;
            end

            FETCH: begin
                iREN = 1'b1;
                if (ihit) begin
                    if (halt_in) begin
                        next_state = HALTED;
                    end else if (dWEN_in) begin
                        if (!datomic_in || sc_ok) begin
                            daddr_n     = daddr_in;
                            dstore_n    = dstore_in;
                            op_write_n  = 1'b1;
                            op_atomic_n = datomic_in;
                            next_state  = DATA;
                        end else begin
                            pc_en        = 1'b1;
                            link_valid_n = 1'b0;
                        end
                    end else if (dREN_in) begin
                        daddr_n     = daddr_in;
                        op_write_n  = 1'b0;
                        op_atomic_n = datomic_in;
                        next_state  = DATA;
                    end else begin
                        pc_en = 1'b1;
                    end
                end
            end

            DATA: begin
                dREN = !op_write;
                dWEN = op_write;
                if (dhit) begin
                    pc_en      = 1'b1;
                    next_state = FETCH;
                    if (!op_write) begin
                        load_data = dload;
                        if (op_atomic) begin
                            link_valid_n = 1'b1;
                            link_addr_n  = daddr[31:2];
                        end
                    end else if (op_atomic) begin
                        // An SC approved in FETCH completes as a success even
                        // if the link was snooped away while in flight.
                        load_data    = 32'h1;
                        link_valid_n = 1'b0;
                    end else if (daddr[31:2] == link_addr) begin
                        link_valid_n = 1'b0;
                    end
                end
            end

            HALTED: begin
                halt_out = 1'b1;
            end

            default: begin
                next_state = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_memory_request_unit.sv
// ---------------------------------------------------------------------------
// tb_memory_request_unit
//
// Directed scenarios followed by a randomized instruction stream. Expected
// values come from a transaction-level model of the reservation (a valid
// bit plus a word address) and of each instruction's commit behaviour.
// ---------------------------------------------------------------------------
module tb_memory_request_unit;

    logic        CLK;
    logic        nRST;
    logic        dREN_in, dWEN_in, datomic_in, halt_in;
    logic [31:0] daddr_in, dstore_in;
    logic        ihit, dhit;
    logic [31:0] dload;
    logic        snoop_inv;
    logic [31:0] snoop_addr;
    logic        iREN, dREN, dWEN;
    logic [31:0] daddr, dstore;
    logic        pc_en;
    logic [31:0] load_data;
    logic        halt_out, link_valid;

    int nChecks = 0;
    int nErrors = 0;

    // Reference model of the reservation
    bit          mLink;
    logic [31:0] mLinkAddr;

    memory_request_unit dut (
        .CLK(CLK), .nRST(nRST),
        .dREN_in(dREN_in), .dWEN_in(dWEN_in), .datomic_in(datomic_in), .halt_in(halt_in),
        .daddr_in(daddr_in), .dstore_in(dstore_in),
        .ihit(ihit), .dhit(dhit), .dload(dload),
        .snoop_inv(snoop_inv), .snoop_addr(snoop_addr),
        .iREN(iREN), .dREN(dREN), .dWEN(dWEN),
        .daddr(daddr), .dstore(dstore),
        .pc_en(pc_en), .load_data(load_data),
        .halt_out(halt_out), .link_valid(link_valid)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #2000000;
        $display("[TB] FAIL timeout observed=running expected=finished");
        $fatal(1, "[TB] simulation time limit reached");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        nChecks++;
        assert (observed === expected)
        else begin
            nErrors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic clearInputs();
        dREN_in = 0; dWEN_in = 0; datomic_in = 0; halt_in = 0;
        daddr_in = '0; dstore_in = '0;
        ihit = 0; dhit = 0; dload = '0;
        snoop_inv = 0; snoop_addr = '0;
    endtask

    // Holds reset (if not already low), checks outputs while in reset, then
    // releases and checks the IDLE cycle and the first FETCH cycle.
    task automatic doReset();
        clearInputs();
        nRST = 0;
        #1;
        checkOutput("rst_iREN", 32'(iREN), 0);
        checkOutput("rst_dREN", 32'(dREN), 0);
        checkOutput("rst_halt", 32'(halt_out), 0);
        checkOutput("rst_link", 32'(link_valid), 0);
        tick();
        tick();
        nRST = 1;
        #2;
        checkOutput("idle_iREN", 32'(iREN), 0);
        checkOutput("idle_dWEN", 32'(dWEN), 0);
        checkOutput("idle_pc_en", 32'(pc_en), 0);
        checkOutput("idle_daddr", daddr, 0);
        checkOutput("idle_load", load_data, 0);
        mLink = 0;
        mLinkAddr = '0;
        tick();
        checkOutput("fetch_iREN", 32'(iREN), 1);
    endtask

    // Runs one instruction starting in FETCH. iw idle fetch cycles precede
    // ihit; a memory access takes dw+1 data cycles. Snoops may be applied in
    // the ihit cycle and/or in the dhit cycle.
    task automatic applyStimulus(input bit rd, input bit wr, input bit at,
                                 input logic [31:0] addr, input logic [31:0] store,
                                 input logic [31:0] dl, input int iw, input int dw,
                                 input bit snI, input bit snD, input logic [31:0] snA);
        bit isLoad, isSc, scOk, memOp;
        isLoad = !wr && rd;
        isSc   = wr && at;

        for (int k = 0; k < iw; k++) begin
            clearInputs();
            dREN_in = 1'($urandom); dWEN_in = 1'($urandom); halt_in = 1'($urandom);
            daddr_in = $urandom;
            #2;
            checkOutput("wait_iREN", 32'(iREN), 1);
            checkOutput("wait_pc_en", 32'(pc_en), 0);
            tick();
        end

        clearInputs();
        dREN_in = rd; dWEN_in = wr; datomic_in = at;
        daddr_in = addr; dstore_in = store; ihit = 1;
        snoop_inv = snI; snoop_addr = snA;
        if (snI && snA[31:2] == mLinkAddr[31:2]) mLink = 0;
        scOk  = mLink && addr[31:2] == mLinkAddr[31:2];
        memOp = isLoad || (wr && !at) || (isSc && scOk);
        #2;
        checkOutput("ihit_iREN", 32'(iREN), 1);
        checkOutput("ihit_dWEN", 32'(dWEN), 0);
        checkOutput("ihit_pc_en", 32'(pc_en), 32'(!memOp));
        if (!memOp) checkOutput("ihit_load", load_data, 0);
        if (isSc && !scOk) mLink = 0;
        tick();

        if (memOp) begin
            for (int k = 0; k <= dw; k++) begin
                clearInputs();
                dhit = (k == dw);
                dload = dl;
                snoop_inv = snD && (k == dw);
                snoop_addr = snA;
                #2;
                checkOutput("data_iREN", 32'(iREN), 0);
                checkOutput("data_dREN", 32'(dREN), 32'(!wr));
                checkOutput("data_dWEN", 32'(dWEN), 32'(wr));
                checkOutput("data_daddr", daddr, addr);
                if (wr) checkOutput("data_dstore", dstore, store);
                checkOutput("data_pc_en", 32'(pc_en), 32'(k == dw));
                if (k == dw && !wr) checkOutput("load_data", load_data, dl);
                if (k == dw && isSc) checkOutput("sc_result", load_data, 1);
                tick();
            end
            if (snD && snA[31:2] == mLinkAddr[31:2]) mLink = 0;
            if (isLoad && at) begin
                mLink = 1;
                mLinkAddr = addr;
            end else if (isSc) begin
                mLink = 0;
            end else if (wr && addr[31:2] == mLinkAddr[31:2]) begin
                mLink = 0;
            end
        end

        clearInputs();
        #2;
        checkOutput("post_iREN", 32'(iREN), 1);
        checkOutput("link_valid", 32'(link_valid), 32'(mLink));
        tick();
    endtask

    function automatic logic [31:0] pickAddr();
        case ($urandom_range(0, 3))
            0: pickAddr = 32'h200 | 32'($urandom_range(0, 3));
            1: pickAddr = 32'h204;
            2: pickAddr = 32'h300;
            default: pickAddr = {$urandom, 2'b00} >> 2 << 2;
        endcase
    endfunction

    initial begin
        $display("[TB] memory_request_unit bench start");
        doReset();

        // ADD, then LW 0x100 with three data cycles
        applyStimulus(0, 0, 0, 32'h0, 32'h0, 32'h0, 0, 0, 0, 0, 32'h0);
        applyStimulus(1, 0, 0, 32'h100, 32'h0, 32'hDEADBEEF, 0, 2, 0, 0, 32'h0);

        // LL/SC success
        applyStimulus(1, 0, 1, 32'h200, 32'h0, 32'h7, 0, 1, 0, 0, 32'h0);
        checkOutput("ll_sets_link", 32'(mLink), 1);
        applyStimulus(0, 1, 1, 32'h200, 32'h55, 32'h0, 0, 1, 0, 0, 32'h0);

        // LL, snoop 0x204 (no effect), snoop 0x200 (clears), SC fails
        applyStimulus(1, 0, 1, 32'h200, 32'h0, 32'h1, 0, 0, 0, 0, 32'h0);
        applyStimulus(0, 0, 0, 32'h0, 32'h0, 32'h0, 0, 0, 1, 0, 32'h204);
        applyStimulus(0, 0, 0, 32'h0, 32'h0, 32'h0, 0, 0, 1, 0, 32'h200);
        applyStimulus(0, 1, 1, 32'h200, 32'h55, 32'h0, 0, 0, 0, 0, 32'h0);

        // SC to a different word fails; SW to the linked word clears the link
        applyStimulus(1, 0, 1, 32'h200, 32'h0, 32'h1, 0, 0, 0, 0, 32'h0);
        applyStimulus(0, 1, 1, 32'h300, 32'h9, 32'h0, 0, 0, 0, 0, 32'h0);
        applyStimulus(1, 0, 1, 32'h200, 32'h0, 32'h1, 0, 0, 0, 0, 32'h0);
        applyStimulus(0, 1, 0, 32'h202, 32'h9, 32'h0, 1, 2, 0, 0, 32'h0);

        // Snoop in the SC's ihit cycle wins; snoop at LL dhit loses;
        // snoop during an approved SC does not stop it
        applyStimulus(1, 0, 1, 32'h200, 32'h0, 32'h1, 0, 0, 0, 0, 32'h0);
        applyStimulus(0, 1, 1, 32'h200, 32'h3, 32'h0, 0, 0, 1, 0, 32'h200);
        applyStimulus(1, 0, 1, 32'h200, 32'h0, 32'h1, 0, 1, 0, 1, 32'h200);
        applyStimulus(0, 1, 1, 32'h201, 32'h4, 32'h0, 0, 2, 0, 1, 32'h200);

        // Randomized stream
        for (int n = 0; n < 300; n++) begin
            bit rd, wr, at;
            rd = 0; wr = 0; at = 0;
            case ($urandom_range(0, 5))
                1: rd = 1;
                2: begin rd = 1; at = 1; end
                3: wr = 1;
                4: begin wr = 1; at = 1; end
                5: begin rd = 1; wr = 1; end
                default: ;
            endcase
            applyStimulus(rd, wr, at, pickAddr(), $urandom, $urandom,
                          $urandom_range(0, 2), $urandom_range(0, 3),
                          ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0), pickAddr());
        end

        // HALT is sticky and silences all requests
        clearInputs();
        halt_in = 1; dREN_in = 1; ihit = 1;
        #2;
        checkOutput("halt_ihit_pc_en", 32'(pc_en), 0);
        tick();
        for (int k = 0; k < 10; k++) begin
            clearInputs();
            ihit = 1'($urandom); dhit = 1'($urandom); dREN_in = 1'($urandom);
            #2;
            checkOutput("halted_flag", 32'(halt_out), 1);
            checkOutput("halted_reqs", {29'b0, iREN, dREN, dWEN}, 0);
            checkOutput("halted_pc_en", 32'(pc_en), 0);
            tick();
        end

        // Reset pulled mid-DATA
        doReset();
        applyStimulus(1, 0, 1, 32'h200, 32'h0, 32'h1, 0, 0, 0, 0, 32'h0);
        clearInputs();
        dREN_in = 1; daddr_in = 32'h400; ihit = 1;
        tick();
        clearInputs();
        #2;
        checkOutput("mid_data_dREN", 32'(dREN), 1);
        nRST = 0;
        #1;
        checkOutput("async_dREN", 32'(dREN), 0);
        checkOutput("async_halt", 32'(halt_out), 0);
        checkOutput("async_link", 32'(link_valid), 0);
        doReset();
        applyStimulus(0, 1, 1, 32'h200, 32'h1, 32'h0, 0, 0, 0, 0, 32'h0);

        $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
        $finish;
    end

endmodule

// File: doc/memory_request_unit.md
# memory_request_unit

Sequential memory-request sequencer that consumes the decoded per-instruction controls: dREN, dWEN, datomic and halt. It drives the instruction- and data-side request handshakes to the cache/memory controller and issues the PC-advance enable. It also owns the LL/SC reservation (link register), including snoop invalidation, and reports the SC result word to the writeback mux. It sits between the decode stage and the cache port of the datapath.

## Interface
- No parameters; word width fixed at 32, word address compare uses bits [31:2].
- CLK  in  1  system clock, all state on rising edge.
- nRST  in  1  reset, asynchronous, active-low.
- dREN_in  in  1  decoded load request (LW, LL).
- dWEN_in  in  1  decoded store request (SW, SC).
- datomic_in  in  1  decoded atomic flag (LL, SC).
- halt_in  in  1  decoded HALT.
- daddr_in  in  32  effective address from ALU.
- dstore_in  in  32  store data (rt).
- ihit  in  1  instruction fetch complete.
- dhit  in  1  data access complete.
- dload  in  32  data returned by memory.
- snoop_inv  in  1  another agent wrote snoop_addr.
- snoop_addr  in  32  invalidating write address.
- iREN  out  1  instruction read request.
- dREN  out  1  data read request.
- dWEN  out  1  data write request.
- daddr  out  32  registered data address.
- dstore  out  32  registered store data.
- pc_en  out  1  advance PC / commit instruction this cycle.
- load_data  out  32  load or SC result for writeback, valid when pc_en.
- halt_out  out  1  sticky halted flag.
- link_valid  out  1  reservation present (observability).

## Operation
- States: IDLE, FETCH, DATA, HALTED. Reset: state=IDLE; every output 0; link_valid=0, link_addr=0, op regs 0.
- IDLE: all outputs 0; unconditionally FETCH next cycle.
- FETCH: iREN=1. Decode inputs are sampled only in a cycle with ihit=1:
  - halt_in: go to HALTED. No pc_en.
  - Plain or LL load (dREN_in): register daddr_in, op=read, atomic=datomic_in, then go to DATA. pc_en=0.
  - Plain store (dWEN_in && !datomic_in): register daddr_in and dstore_in, then go to DATA.
  - SC with link_valid && daddr_in[31:2]==link_addr[31:2], evaluated after same-cycle snoop: register, then go to DATA.
  - SC failing the check: no memory access; pc_en=1, load_data=0, link_valid cleared, stay in FETCH.
  - Otherwise (non-memory instruction): pc_en=1, load_data=0, stay in FETCH.
- DATA: iREN=0; dREN or dWEN=1 per registered op; daddr and dstore are held stable. On dhit: pc_en=1, return to FETCH.
  - Load: load_data=dload.
  - LL: additionally link_valid=1, link_addr=daddr.
  - SC success: load_data=32'h1, link_valid=0.
  - Plain SW whose address word equals link_addr: link_valid=0.
- HALTED: halt_out=1, all requests 0, pc_en=0; sticky until nRST.
- Snoop: snoop_inv && snoop_addr[31:2]==link_addr[31:2] clears link_valid.
  - Same cycle as an LL dhit: the new reservation wins (link set).
  - Same cycle as an SC check in FETCH: the snoop wins (SC fails).
  - During DATA for an already-approved SC: the SC still completes as success.
- Simultaneous dREN_in and dWEN_in: dWEN_in takes priority. halt_in takes priority over both.

## Timing
- Non-memory instruction: pc_en asserts in the ihit cycle (combinational from state and ihit).
- Memory instruction: ihit in cycle N; dREN/dWEN assert from N+1; pc_en and load_data are combinational in the dhit cycle M ≥ N+1; FETCH resumes at M+1.
- Failed SC: commits in its ihit cycle, zero data-side cycles.
- dREN and dWEN are never both 1. iREN and data requests are never both 1.
- Reset asserted mid-DATA: requests drop immediately (async), link cleared, restart via IDLE.

## Test plan
- Reset release: cycle 0 all outputs 0, IDLE; cycle 1 iREN=1. An ADD with ihit gives pc_en=1 in the same cycle, dREN=dWEN=0.
- LW at 0x100, dhit after 3 cycles, dload=0xDEADBEEF: dREN=1 for 3 cycles, daddr=0x100, pc_en=1 with load_data=0xDEADBEEF, then iREN=1.
- LL 0x200, then SC 0x200 with dstore=0x55: LL sets link_valid=1; SC issues dWEN with daddr=0x200 and dstore=0x55; on dhit load_data=1, link_valid=0.
- LL 0x200, then snoop_inv at 0x204, then snoop_inv at 0x200, then SC 0x200:
  - 0x204 leaves the link intact.
  - 0x200 clears it.
  - The SC gives pc_en=1 with load_data=0, dWEN never asserted.
- SC at 0x300 while linked to 0x200: the SC fails without a memory access. Separately, an SW to 0x200 while linked clears link_valid.
- HALT with ihit: halt_out=1 next cycle and all requests stay 0 for 10 cycles. nRST pulsed low mid-DATA: dREN drops asynchronously and halt_out=0.
